blob_centroid: RTL

Per-frame colour-blob tracker that sits directly upstream of the sprite renderer. It accumulates the coordinates of thresholded "hit" pixels over one video frame and divides the sums by the hit count to get the centroid. It then converts the centroid to a top-left sprite origin (blob_x, blob_y), which drives the renderer's x/y inputs on the next frame. Division runs serially during vertical blanking while the next frame accumulates.

---
 rtl/blob_centroid_pkg.sv | 25 ++
 rtl/blob_centroid_serial_divider.sv | 81 ++++++++
 rtl/blob_centroid.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/blob_centroid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blob_centroid_pkg
// Purpose  : Shared active-area constants, accumulator widths and FSM states
//            for the blob tracker, sprite renderer and VGA timing.
// Revision : 1.0
// ============================================================================
package blob_centroid_pkg;

    localparam int c_ACTIVE_W  = 1024;
    localparam int c_ACTIVE_H  = 768;
    localparam int c_HCOUNT_W  = $clog2(c_ACTIVE_W) + 1;
    localparam int c_VCOUNT_W  = $clog2(c_ACTIVE_H);
    localparam int c_SUM_W     = 30;
    localparam int c_CNT_W     = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV_X = 2'd1,
        ST_DIV_Y = 2'd2,
        ST_DONE  = 2'd3
    } blob_state_e;

endpackage
`default_nettype wire

// File: rtl/blob_centroid_serial_divider.sv
`default_nettype none
// ============================================================================
// Module   : blob_centroid_serial_divider
// Purpose  : Restoring serial divider, one quotient bit per cycle; done
//            pulses exactly DIVIDEND_W cycles after start.
// Revision : 1.0
// ============================================================================
module blob_centroid_serial_divider #(
    parameter int DIVIDEND_W = 30,
    parameter int DIVISOR_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic                  done
);

    localparam int c_STEP_W = $clog2(DIVIDEND_W + 1);

    logic [DIVIDEND_W-1:0] r_quo;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_div;
    logic [c_STEP_W-1:0]   r_steps;
    logic                  r_run;
    logic                  r_done;

    logic [DIVIDEND_W-1:0] w_quo_in;
    logic [DIVISOR_W-1:0]  w_rem_in;
    logic [DIVISOR_W-1:0]  w_div_in;
    logic [DIVISOR_W:0]    w_trial;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_rem_nxt;
    logic [DIVIDEND_W-1:0] w_quo_nxt;

    // The first step is taken on the start cycle itself, which keeps the
    // latency at exactly DIVIDEND_W cycles.
    assign w_quo_in  = start ? dividend : r_quo;
    assign w_rem_in  = start ? '0 : r_rem;
    assign w_div_in  = start ? divisor : r_div;
    assign w_trial   = {w_rem_in, w_quo_in[DIVIDEND_W-1]};
    assign w_ge      = (w_trial >= {1'b0, w_div_in});
    assign w_rem_nxt = w_ge ? DIVISOR_W'(w_trial - {1'b0, w_div_in})
                            : DIVISOR_W'(w_trial);
    assign w_quo_nxt = {w_quo_in[DIVIDEND_W-2:0], w_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_steps <= '0;
            r_run   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_quo   <= w_quo_nxt;
                r_rem   <= w_rem_nxt;
                r_div   <= divisor;
                r_steps <= c_STEP_W'(DIVIDEND_W - 1);
                r_run   <= 1'b1;
            end else if (r_run) begin
                r_quo   <= w_quo_nxt;
                r_rem   <= w_rem_nxt;
                r_steps <= r_steps - c_STEP_W'(1);
                if (r_steps == c_STEP_W'(1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quotient = r_quo;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: rtl/blob_centroid.sv
`default_nettype none
// ============================================================================
// Module   : blob_centroid
// Purpose  : Per-frame hit-pixel centroid tracker producing a sprite origin;
//            divides during blanking while the next frame accumulates.
// Revision : 1.0
// ============================================================================
module blob_centroid
    import blob_centroid_pkg::*;
#(
    parameter int HALF_W     = 32,
    parameter int HALF_H     = 32,
    parameter int MIN_PIXELS = 64,
    parameter int SUM_W      = c_SUM_W,
    parameter int CNT_W      = c_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [c_HCOUNT_W-1:0] hcount,
    input  logic [c_VCOUNT_W-1:0] vcount,
    input  logic                  pix_valid,
    input  logic                  pix_hit,
    input  logic                  frame_end,
    output logic [c_HCOUNT_W-1:0] centroid_x,
    output logic [c_VCOUNT_W-1:0] centroid_y,
    output logic [c_HCOUNT_W-1:0] blob_x,
    output logic [c_VCOUNT_W-1:0] blob_y,
    output logic                  found,
    output logic                  busy,
    output logic                  update
);

    blob_state_e r_state;
    blob_state_e w_state_nxt;
    logic        r_start;
    logic        w_start_nxt;

    logic [SUM_W-1:0] r_sum_x, r_sum_y, w_sum_x_nxt, w_sum_y_nxt;
    logic [SUM_W-1:0] r_snap_x, r_snap_y;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_snap_cnt;
    logic             w_hit;
    logic             w_reject;
    logic             w_accept;

    logic [SUM_W-1:0]      w_dividend;
    logic [SUM_W-1:0]      w_quo;
    logic                  w_div_done;
    logic [c_HCOUNT_W-1:0] r_qx;
    logic [c_VCOUNT_W-1:0] w_qy;

    logic [c_HCOUNT_W-1:0] r_cx, r_bx;
    logic [c_VCOUNT_W-1:0] r_cy, r_by;
    logic                  r_found;

    // Post-update sums, so a hit coincident with frame_end is included.
    assign w_hit       = pix_valid & pix_hit;
    assign w_sum_x_nxt = r_sum_x + (w_hit ? SUM_W'(hcount) : '0);
    assign w_sum_y_nxt = r_sum_y + (w_hit ? SUM_W'(vcount) : '0);
    assign w_cnt_nxt   = r_cnt + CNT_W'(w_hit);
    assign w_reject    = (w_cnt_nxt < CNT_W'(MIN_PIXELS));
    assign w_accept    = frame_end && (r_state == ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_x    <= '0;
            r_sum_y    <= '0;
            r_cnt      <= '0;
            r_snap_x   <= '0;
            r_snap_y   <= '0;
            r_snap_cnt <= '0;
        end else begin
            if (frame_end) begin
                r_sum_x <= '0;
                r_sum_y <= '0;
                r_cnt   <= '0;
            end else begin
                r_sum_x <= w_sum_x_nxt;
                r_sum_y <= w_sum_y_nxt;
                r_cnt   <= w_cnt_nxt;
            end
            if (w_accept) begin
                r_snap_x   <= w_sum_x_nxt;
                r_snap_y   <= w_sum_y_nxt;
                r_snap_cnt <= w_cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_end) begin
                    if (w_reject) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_DIV_X;
                        w_start_nxt = 1'b1;
                    end
                end
            end
            ST_DIV_X: begin
                if (w_div_done) begin
                    w_state_nxt = ST_DIV_Y;
                    w_start_nxt = 1'b1;
                end
            end
            ST_DIV_Y: begin
                if (w_div_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // One divider is shared: x sum first, then y sum.
    assign w_dividend = (r_state == ST_DIV_Y) ? r_snap_y : r_snap_x;
    assign w_qy       = c_VCOUNT_W'(w_quo);

    blob_centroid_serial_divider #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (r_start),
        .dividend (w_dividend),
        .divisor  (r_snap_cnt),
        .quotient (w_quo),
        .done     (w_div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qx    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_bx    <= '0;
            r_by    <= '0;
            r_found <= 1'b0;
        end else begin
            if (w_accept && w_reject) begin
                r_found <= 1'b0;
            end
            if ((r_state == ST_DIV_X) && w_div_done) begin
                r_qx <= c_HCOUNT_W'(w_quo);
            end
            if ((r_state == ST_DIV_Y) && w_div_done) begin
                r_cx    <= r_qx;
                r_cy    <= w_qy;
                r_bx    <= (r_qx < c_HCOUNT_W'(HALF_W)) ? '0 : r_qx - c_HCOUNT_W'(HALF_W);
                r_by    <= (w_qy < c_VCOUNT_W'(HALF_H)) ? '0 : w_qy - c_VCOUNT_W'(HALF_H);
                r_found <= 1'b1;
            end
        end
    end

    assign centroid_x = r_cx;
    assign centroid_y = r_cy;
    assign blob_x     = r_bx;
    assign blob_y     = r_by;
    assign found      = r_found;
    assign busy       = (r_state != ST_IDLE);
    assign update     = (r_state == ST_DONE);

endmodule
`default_nettype wire
